// File: rtl/fetch_redirect_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// fetch_redirect_ctrl_pkg
//   Shared types and constants for the instruction-fetch sequencer:
//   address/instruction widths, the default reset PC, the fetch-queue entry
//   layout {pc, instr}, and the classification of an accepted redirect.
// ---------------------------------------------------------------------------
package fetch_redirect_ctrl_pkg;

  localparam int ADDR_W  = 32;
  localparam int INSTR_W = 32;

  typedef logic [ADDR_W-1:0]  addr_t;
  typedef logic [INSTR_W-1:0] instr_t;

  localparam addr_t DEFAULT_RESET_PC = 32'h0000_3000;

  // Fetch queue occupancy; the queue is fixed at two entries.
  typedef logic [1:0] qcount_t;
  localparam qcount_t QDEPTH = 2'd2;

  // One queued instruction, head of the queue feeds the D stage.
  typedef struct packed {
    addr_t  pc;
    instr_t instr;
  } fq_entry_t;

  // Where the delay slot lives when a redirect is accepted.
  typedef enum logic [1:0] {
    REDIR_NONE,      // no redirect accepted this cycle
    REDIR_HEAD,      // delay slot is the queue head, popping now
    REDIR_INFLIGHT,  // delay slot is the live outstanding request
    REDIR_DEFER      // delay slot not yet requested
  } redir_kind_e;

  // Sequential fetch advance, wraps modulo 2^32.
  function automatic addr_t next_seq_pc(input addr_t pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/fetch_redirect_ctrl_if.sv
// ---------------------------------------------------------------------------
// fetch_redirect_ctrl_if
//   Bundles the instruction-memory request channel and the fetch/decode
//   boundary of the fetch sequencer.
//     imem_req/imem_addr   : request to instruction memory (held until ack)
//     imem_ack/imem_rdata  : one-cycle completion pulse with instruction
//     fd_valid/fd_pc/fd_instr : head of the fetch queue presented to D
//     d_ready              : D advances this cycle
//     npc_redirect/npc_target : taken branch/jump leaving D and its target
//   master = fetch sequencer, slave = memory plus D stage / next-PC logic.
// ---------------------------------------------------------------------------
interface fetch_redirect_ctrl_if;
  import fetch_redirect_ctrl_pkg::*;

  logic   imem_req;
  addr_t  imem_addr;
  logic   imem_ack;
  instr_t imem_rdata;

  logic   fd_valid;
  addr_t  fd_pc;
  instr_t fd_instr;

  logic   d_ready;
  logic   npc_redirect;
  addr_t  npc_target;

  modport master (
    output imem_req, imem_addr, fd_valid, fd_pc, fd_instr,
    input  imem_ack, imem_rdata, d_ready, npc_redirect, npc_target
  );

  modport slave (
    input  imem_req, imem_addr, fd_valid, fd_pc, fd_instr,
    output imem_ack, imem_rdata, d_ready, npc_redirect, npc_target
  );

endinterface

// File: rtl/fetch_redirect_ctrl_fetch_queue.sv
// ---------------------------------------------------------------------------
// fetch_queue
//   Two-entry in-order FIFO of fetched instructions.
//   Ports:
//     clk, reset        : clock, synchronous active-high reset
//     push, push_entry  : append an entry (caller guarantees space)
//     pop               : remove the head
//     squash_tail       : discard every entry behind the head
//     head, head_valid  : oldest entry and whether it exists
//     count             : current occupancy
//   Within one cycle the order is squash_tail, then pop, then push, so a
//   push lands behind whatever survives the squash and pop.
// ---------------------------------------------------------------------------
module fetch_queue
  import fetch_redirect_ctrl_pkg::*;
(
  input  logic      clk,
  input  logic      reset,
  input  logic      push,
  input  fq_entry_t push_entry,
  input  logic      pop,
  input  logic      squash_tail,
  output fq_entry_t head,
  output logic      head_valid,
  output qcount_t   count
);

  fq_entry_t slot_q [QDEPTH];
  fq_entry_t slot_n [QDEPTH];
  qcount_t   count_q;
  qcount_t   count_n;
  qcount_t   kept;
  logic      popped;

  always_comb begin
    // NOTE: every value written here gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    slot_n = slot_q;
    kept   = count_q;

    if (squash_tail && (kept > 2'd1)) kept = 2'd1;

    popped = pop && (kept != 2'd0);
    if (popped) begin
      kept      = kept - 2'd1;
      slot_n[0] = slot_q[1];
    end

    if (push && (kept != QDEPTH)) slot_n[kept[0]] = push_entry;

    count_n = kept + qcount_t'(push && (kept != QDEPTH));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
      // NOTE: the storage is cleared on reset only because the head drives
      // fd_pc/fd_instr directly and those must read zero after reset.
      for (int i = 0; i < int'(QDEPTH); i++) slot_q[i] <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignment so every flop
      // samples pre-edge values regardless of process ordering.
      count_q <= count_n;
      slot_q  <= slot_n;
    end
  end

  assign head       = slot_q[0];
  assign head_valid = (count_q != 2'd0);
  assign count      = count_q;

endmodule

// File: rtl/fetch_redirect_ctrl.sv
// ---------------------------------------------------------------------------
// fetch_redirect_ctrl
//   Instruction-fetch sequencer. Owns the fetch PC, keeps at most one request
//   outstanding to a variable-latency instruction memory, buffers returned
//   instructions in a 2-entry queue feeding D, and applies taken
//   branch/jump redirects with MIPS delay-slot semantics (delay slot kept,
//   later wrong-path fetches squashed, fetch resumes at the target).
//   Ports:
//     clk    : clock
//     reset  : synchronous, active-high
//     bus    : fetch_redirect_ctrl_if.master (imem request channel, fd
//              queue head, d_ready, npc_redirect/npc_target)
//   Parameters:
//     RESET_PC : first fetch address after reset
// ---------------------------------------------------------------------------
module fetch_redirect_ctrl
  import fetch_redirect_ctrl_pkg::*;
#(
  parameter addr_t RESET_PC = DEFAULT_RESET_PC
)
(
  input  logic                  clk,
  input  logic                  reset,
  fetch_redirect_ctrl_if.master bus
);

  // Architectural state
  addr_t pc_q,         pc_n;          // next address to request
  logic  req_q,        req_n;         // request outstanding
  addr_t addr_q,       addr_n;        // address of outstanding request
  logic  drop_q,       drop_n;        // outstanding response is wrong-path
  logic  redir_pend_q, redir_pend_n;  // delay slot still to be requested
  addr_t redir_tgt_q,  redir_tgt_n;   // target to adopt after that request

  // Per-cycle decode
  logic        pop;
  logic        ack_live;
  logic        redir_acc;
  redir_kind_e redir_kind;
  logic        squash;
  logic        push;
  fq_entry_t   push_entry;
  qcount_t     count_after;
  logic        issue;

  // Queue view
  fq_entry_t q_head;
  logic      q_valid;
  qcount_t   q_count;

  fetch_queue u_queue (
    .clk         (clk),
    .reset       (reset),
    .push        (push),
    .push_entry  (push_entry),
    .pop         (pop),
    .squash_tail (squash),
    .head        (q_head),
    .head_valid  (q_valid),
    .count       (q_count)
  );

  always_comb begin
    pop       = q_valid && bus.d_ready;
    // An ack only means something while a request is actually outstanding.
    ack_live  = req_q && bus.imem_ack;
    redir_acc = bus.npc_redirect && bus.d_ready;

    redir_kind = REDIR_NONE;
    if (redir_acc) begin
      if (q_valid)                redir_kind = REDIR_HEAD;
      else if (req_q && !drop_q)  redir_kind = REDIR_INFLIGHT;
      else                        redir_kind = REDIR_DEFER;
    end

    // Head is the delay slot: everything behind it, including a response
    // arriving now, is wrong-path.
    squash = (redir_kind == REDIR_HEAD);
    push   = ack_live && !drop_q && !squash;

    push_entry.pc    = addr_q;
    push_entry.instr = bus.imem_rdata;

    // Occupancy once this edge settles; with a head squash the head is
    // popping too, so nothing is left.
    count_after = squash ? 2'd0
                         : q_count - qcount_t'(pop) + qcount_t'(push);

    // Reserve a queue slot for every request so a response can always land.
    issue = (!req_q || ack_live) && (count_after < QDEPTH);

    pc_n         = pc_q;
    req_n        = req_q;
    addr_n       = addr_q;
    drop_n       = drop_q;
    redir_pend_n = redir_pend_q;
    redir_tgt_n  = redir_tgt_q;

    if (ack_live) begin
      req_n  = 1'b0;
      drop_n = 1'b0;
    end

    case (redir_kind)
      REDIR_HEAD: begin
        pc_n         = bus.npc_target;
        redir_pend_n = 1'b0;
        if (req_q && !bus.imem_ack) drop_n = 1'b1;
      end
      REDIR_INFLIGHT: begin
        pc_n         = bus.npc_target;
        redir_pend_n = 1'b0;
      end
      REDIR_DEFER: begin
        redir_pend_n = 1'b1;
        redir_tgt_n  = bus.npc_target;
      end
      default: ;
    endcase

    // pc_n already holds the target when the redirect was resolved above,
    // so a request issued at the accepting edge never goes down the wrong
    // path. A deferred redirect sends the delay slot first, then jumps.
    if (issue) begin
      req_n  = 1'b1;
      addr_n = pc_n;
      if (redir_pend_n) begin
        pc_n         = redir_tgt_n;
        redir_pend_n = 1'b0;
      end else begin
        pc_n = next_seq_pc(pc_n);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q         <= RESET_PC;
      req_q        <= 1'b0;
      addr_q       <= '0;
      drop_q       <= 1'b0;
      redir_pend_q <= 1'b0;
      redir_tgt_q  <= '0;
    end else begin
      pc_q         <= pc_n;
      req_q        <= req_n;
      addr_q       <= addr_n;
      drop_q       <= drop_n;
      redir_pend_q <= redir_pend_n;
      redir_tgt_q  <= redir_tgt_n;
    end
  end

  assign bus.imem_req  = req_q;
  assign bus.imem_addr = addr_q;
  assign bus.fd_valid  = q_valid;
  assign bus.fd_pc     = q_head.pc;
  assign bus.fd_instr  = q_head.instr;

endmodule
